// File: rtl/riscv151_pkg.sv
// Shared definitions for the riscv151 multicycle core: opcodes, funct
// fields, CSR and MMIO addresses, FSM states and ALU operations.
package riscv151_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [11:0] CSR_TOHOST = 12'h51E;

  localparam logic [31:0] MMIO_CYCLE     = 32'h8000_0010;
  localparam logic [31:0] MMIO_CYCLE_CLR = 32'h8000_0018;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt selects SUB/SRA; the caller decides when funct7 is meaningful.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv151_if.sv
// Memory port bundle between the core (master) and a RAM (slave).
// There is no valid/ready: the slave accepts a request every cycle, a
// nonzero be commits the write at the clock edge, and rdata holds the word
// addressed in the previous cycle.
interface riscv151_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output be, input rdata);
  modport slave  (input addr, input wdata, input be, output rdata);
endinterface

// File: rtl/riscv151_alu.sv
// RV32I integer ALU with branch-compare flags on the same operands.
module riscv151_alu
  import riscv151_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);
  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  // Result select; shifts use only b[4:0].
  always_comb begin
    result = a + b;
    case (op)
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, lt};
      ALU_SLTU: result = {31'b0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = 32'($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = a + b;
    endcase
  end
endmodule

// File: rtl/riscv151_ram.sv
// Generic byte-enable synchronous RAM decoding addr[31:28]==1.
// Out-of-region reads return 0 and out-of-region writes are dropped.
module riscv151_ram #(
  parameter int DEPTH = 4096
) (
  input logic        clk,
  riscv151_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [0:DEPTH-1];
  logic          hit;
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign hit         = (bus.addr[31:28] == 4'h1);
  assign idx         = bus.addr[AW+1:2];
  assign unused_addr = ^{bus.addr[27:AW+2], bus.addr[1:0]};

  // One-cycle read plus per-byte write of the decoded word.
  always_ff @(posedge clk) begin
    bus.rdata <= hit ? mem[idx] : '0;
    for (int i = 0; i < 4; i++) begin
      if (hit && bus.be[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
  end
endmodule

// File: rtl/riscv151_cpu.sv
// Multicycle RV32I core: FETCH, DECODE, EXEC, (MEM for loads), WB.
// Optional cycle counter at 0x8000_0010 (clear via store to 0x8000_0018)
// is built only when RISCV151_CYCLE_COUNTER_EN is defined.
module riscv151_cpu
  import riscv151_pkg::*;
#(
  parameter int          CPU_CLOCK_FREQ = 50_000_000,
  parameter logic [31:0] RESET_PC       = 32'h1000_0000,
  parameter int          MEM_DEPTH      = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FPGA_SERIAL_RX,
  output logic        FPGA_SERIAL_TX,
  output logic [31:0] csr
);
  riscv151_if imem_bus ();
  riscv151_if dmem_bus ();

  riscv151_ram #(.DEPTH(MEM_DEPTH)) imem (.clk(clk), .bus(imem_bus.slave));
  riscv151_ram #(.DEPTH(MEM_DEPTH)) dmem (.clk(clk), .bus(dmem_bus.slave));

  state_e      state, state_n;
  logic [31:0] pc, npc_q, instr_q, rs1_q, rs2_q, rd_data_q, tohost;
  logic [1:0]  ea_lo_q;
  logic        wb_en_q;
  logic [31:0] rf [0:31];

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, ra1, ra2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;
  logic [31:0] alu_a, alu_b, alu_res, exec_res, next_pc, csr_src;
  logic [31:0] store_wdata, load_word, load_res;
  logic [3:0]  store_be;
  alu_op_e     alu_op;
  logic        eq, lt, ltu, br_taken, wb_en, csr_op, csr_hit, unused_ok;

  assign FPGA_SERIAL_TX = 1'b1;
  assign csr            = tohost;
  assign unused_ok      = ^{FPGA_SERIAL_RX, 32'(CPU_CLOCK_FREQ)};

  assign opc = instr_q[6:0];
  assign rd  = instr_q[11:7];
  assign f3  = instr_q[14:12];
  assign f7  = instr_q[31:25];
  assign ra1 = imem_bus.rdata[19:15];
  assign ra2 = imem_bus.rdata[24:20];

  assign imm_i    = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u    = {instr_q[31:12], 12'b0};
  assign imm_j    = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  assign csr_op  = (opc == OPC_SYSTEM) && ((f3 == F3_CSRRW) || (f3 == F3_CSRRWI));
  assign csr_hit = (instr_q[31:20] == CSR_TOHOST);
  assign csr_src = (f3 == F3_CSRRWI) ? {27'b0, instr_q[19:15]} : rs1_q;

  // Fetch always addresses the current PC; imem is never written.
  assign imem_bus.addr  = pc;
  assign imem_bus.wdata = '0;
  assign imem_bus.be    = '0;

  // Data address is the ALU sum; the write is suppressed while rst is high
  // so an aborted store never reaches memory.
  assign dmem_bus.addr  = alu_res;
  assign dmem_bus.wdata = store_wdata;
  assign dmem_bus.be    = (state == S_EXEC && opc == OPC_STORE && !rst) ? store_be : 4'b0000;

  riscv151_alu u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .result(alu_res), .eq(eq), .lt(lt), .ltu(ltu)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  // Next state: loads take the extra MEM cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: state_n = S_EXEC;
      S_EXEC:   state_n = (opc == OPC_LOAD) ? S_MEM : S_WB;
      S_MEM:    state_n = S_WB;
      default:  state_n = S_FETCH;
    endcase
  end

  // ALU operand and operation selection per opcode.
  always_comb begin
    alu_a  = rs1_q;
    alu_b  = imm_i;
    alu_op = ALU_ADD;
    case (opc)
      OPC_OP: begin
        alu_b  = rs2_q;
        alu_op = alu_decode(f3, f7 == F7_ALT);
      end
      OPC_OP_IMM: alu_op = alu_decode(f3, (f7 == F7_ALT) && (f3 == F3_SR));
      OPC_BRANCH: alu_b  = rs2_q;
      OPC_STORE:  alu_b  = imm_s;
      OPC_LUI:    begin alu_a = '0; alu_b = imm_u; end
      OPC_AUIPC:  begin alu_a = pc; alu_b = imm_u; end
      default: ;
    endcase
  end

  // Execute: result to write back, next PC, and write-back enable.
  always_comb begin
    exec_res = alu_res;
    next_pc  = pc_plus4;
    wb_en    = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = eq;
      F3_BNE:  br_taken = !eq;
      F3_BLT:  br_taken = lt;
      F3_BGE:  br_taken = !lt;
      F3_BLTU: br_taken = ltu;
      F3_BGEU: br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM, OPC_LOAD: wb_en = 1'b1;
      OPC_JAL: begin
        exec_res = pc_plus4;
        next_pc  = pc + imm_j;
        wb_en    = 1'b1;
      end
      OPC_JALR: begin
        exec_res = pc_plus4;
        next_pc  = {alu_res[31:1], 1'b0};
        wb_en    = 1'b1;
      end
      OPC_BRANCH: if (br_taken) next_pc = pc + imm_b;
      OPC_SYSTEM: if (csr_op) begin
        exec_res = csr_hit ? tohost : '0;
        wb_en    = 1'b1;
      end
      default: ;
    endcase
  end

  // Store lane steering; sub-word stores replicate data across lanes.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = rs2_q;
    case (f3)
      F3_SB: begin
        store_be    = 4'b0001 << alu_res[1:0];
        store_wdata = {4{rs2_q[7:0]}};
      end
      F3_SH: begin
        store_be    = alu_res[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{rs2_q[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef RISCV151_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  logic        cnt_sel_q;

  // Free-running cycle counter; a store to the clear address zeroes it.
  always_ff @(posedge clk) begin
    if (rst) cycle_cnt <= '0;
    else if (state == S_EXEC && opc == OPC_STORE && alu_res == MMIO_CYCLE_CLR) cycle_cnt <= '0;
    else cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Remember whether the pending load targets the counter.
  always_ff @(posedge clk) begin
    if (state == S_EXEC) cnt_sel_q <= (alu_res == MMIO_CYCLE);
  end

  assign load_word = cnt_sel_q ? cycle_cnt : dmem_bus.rdata;
`else
  assign load_word = dmem_bus.rdata;
`endif

  // Load lane extraction and sign/zero extension.
  always_comb begin
    logic [7:0]  lb_byte;
    logic [15:0] lh_half;
    lb_byte  = 8'(load_word >> {ea_lo_q, 3'b000});
    lh_half  = ea_lo_q[1] ? load_word[31:16] : load_word[15:0];
    case (f3)
      F3_LB:   load_res = {{24{lb_byte[7]}}, lb_byte};
      F3_LH:   load_res = {{16{lh_half[15]}}, lh_half};
      F3_LBU:  load_res = {24'b0, lb_byte};
      F3_LHU:  load_res = {16'b0, lh_half};
      default: load_res = load_word;
    endcase
  end

  // Datapath registers advanced by FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      tohost <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          instr_q <= imem_bus.rdata;
          rs1_q   <= (ra1 == 5'd0) ? '0 : rf[ra1];
          rs2_q   <= (ra2 == 5'd0) ? '0 : rf[ra2];
        end
        S_EXEC: begin
          rd_data_q <= exec_res;
          npc_q     <= next_pc;
          wb_en_q   <= wb_en;
          ea_lo_q   <= alu_res[1:0];
          if (csr_op && csr_hit) tohost <= csr_src;
        end
        S_MEM: rd_data_q <= load_res;
        S_WB:  pc <= npc_q;
        default: ;
      endcase
    end
  end

  // Register file write; x0 is never written.
  always_ff @(posedge clk) begin
    if (!rst && state == S_WB && wb_en_q && rd != 5'd0) rf[rd] <= rd_data_q;
  end
endmodule

// File: tb/tb_riscv151_cpu.sv
// Directed-program bench for riscv151_cpu: hand-assembled images are
// loaded into imem and results read from tohost, registers and dmem.
module tb_riscv151_cpu;
  localparam logic [31:0] RESET_PC = 32'h1000_0000;
  localparam logic [31:0] HALT     = 32'h0000_006F;
  localparam logic [6:0]  OPI = 7'b0010011, LD = 7'b0000011, LUI = 7'b0110111;
  localparam logic [6:0]  JALR = 7'b1100111, SYS = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [31:0] csr;

  int n_checks = 0;
  int n_errors = 0;
  int tx_bad   = 0;
  int rst_we   = 0;
  logic [31:0] prog[$];
  logic [31:0] exp_q[$];

  riscv151_cpu dut (
    .clk(clk), .rst(rst), .FPGA_SERIAL_RX(rx), .FPGA_SERIAL_TX(tx), .csr(csr)
  );

  riscv151_if mon_if ();
  assign mon_if.addr  = dut.dmem_bus.addr;
  assign mon_if.wdata = dut.dmem_bus.wdata;
  assign mon_if.be    = dut.dmem_bus.be;
  assign mon_if.rdata = dut.dmem_bus.rdata;

  // clock
  always #5 clk = ~clk;

  always @(negedge clk) if (tx !== 1'b1) tx_bad++;
  always @(posedge clk) if (rst && mon_if.be != 4'b0000) rst_we++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] op_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                       logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] op_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] op_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] op_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] op_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                       logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] csrwi(logic [4:0] v);
    return op_i(12'h51E, v, 3'b101, 5'd0, SYS);
  endfunction

  // Hold reset, load the image (rest of the first 64 words halt), release.
  task automatic run_prog(input int hold);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) dut.imem.mem[i] <= (i < prog.size()) ? prog[i] : HALT;
    repeat (hold) tick();
  endtask

  task automatic wait_csr(input string tag, input logic [31:0] code, input int budget);
    int n = 0;
    while (csr !== code && n < budget) begin
      tick();
      n++;
    end
    check(tag, csr, code);
  endtask

  initial begin
    // reset and tohost pass, exact cycle of the tohost write
    prog = {op_i(12'd1, 5'd0, 3'b000, 5'd1, OPI), op_i(12'h51E, 5'd1, 3'b001, 5'd0, SYS)};
    run_prog(30);
    check("rst_pc", dut.pc, RESET_PC);
    check("rst_csr", csr, 32'h0);
    check("rst_state", 32'(dut.state), 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    check("pass_not_yet", csr, 32'h0);
    tick();
    check("pass_at_cycle7", csr, 32'h1);
    wait_csr("pass_within_20", 32'h1, 13);

    // fail code through csrwi
    prog = {csrwi(5'd7)};
    run_prog(5);
    rst = 1'b0;
    wait_csr("fail_code", 32'h7, 100);
    check("fail_bit0", {31'b0, csr[0]}, 32'h1);
    check("fail_num", {1'b0, csr[31:1]}, 32'h3);

    // branches: x1=5, x2=-1
    prog = {op_i(12'd5, 5'd0, 3'b000, 5'd1, OPI), op_i(12'hFFF, 5'd0, 3'b000, 5'd2, OPI),
            op_b(13'd12, 5'd1, 5'd1, 3'b000), csrwi(5'd3), HALT,
            op_b(13'd12, 5'd1, 5'd2, 3'b100), csrwi(5'd5), HALT,
            op_b(13'd12, 5'd1, 5'd2, 3'b110), csrwi(5'd1), HALT,
            csrwi(5'd7), HALT};
    run_prog(5);
    rst = 1'b0;
    wait_csr("branches", 32'h1, 10000);

    // load/store lanes
    prog = {op_u(20'h80018, 5'd1, LUI), op_i(12'hFFF, 5'd1, 3'b000, 5'd1, OPI),
            op_u(20'h10001, 5'd2, LUI), op_s(12'd0, 5'd1, 5'd2, 3'b010),
            op_i(12'd1, 5'd2, 3'b000, 5'd3, LD), op_i(12'd3, 5'd2, 3'b100, 5'd4, LD),
            op_i(12'd3, 5'd2, 3'b000, 5'd5, LD), op_i(12'd2, 5'd2, 3'b001, 5'd6, LD),
            op_i(12'hAA, 5'd0, 3'b000, 5'd7, OPI), op_s(12'd0, 5'd7, 5'd2, 3'b000),
            op_i(12'd0, 5'd2, 3'b010, 5'd8, LD), csrwi(5'd1)};
    exp_q = {32'h0000_007F, 32'h0000_0080, 32'hFFFF_FF80, 32'hFFFF_8001, 32'h8001_7FAA};
    run_prog(5);
    rst = 1'b0;
    wait_csr("ls_done", 32'h1, 300);
    check("ls_lb_p1", dut.rf[3], exp_q.pop_front());
    check("ls_lbu_p3", dut.rf[4], exp_q.pop_front());
    check("ls_lb_p3", dut.rf[5], exp_q.pop_front());
    check("ls_lh_p2", dut.rf[6], exp_q.pop_front());
    check("ls_lw_after_sb", dut.rf[8], exp_q.pop_front());
    check("ls_dmem_word", dut.dmem.mem[12'h400], 32'h8001_7FAA);

    // ALU corners and JALR to an odd target
    prog = {op_u(20'h80000, 5'd1, LUI), op_i(12'h41F, 5'd1, 3'b101, 5'd2, OPI),
            op_i(12'd1, 5'd0, 3'b000, 5'd4, OPI), op_r(7'h20, 5'd4, 5'd0, 3'b000, 5'd3),
            op_i(12'd5, 5'd0, 3'b000, 5'd0, OPI), op_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5),
            op_r(7'h00, 5'd4, 5'd2, 3'b010, 5'd8), op_r(7'h00, 5'd4, 5'd2, 3'b011, 5'd9),
            op_u(20'h10000, 5'd6, LUI), op_i(12'd49, 5'd6, 3'b000, 5'd7, JALR),
            csrwi(5'd5), HALT, csrwi(5'd1), HALT};
    run_prog(5);
    rst = 1'b0;
    wait_csr("alu_done", 32'h1, 300);
    repeat (10) tick();
    check("alu_srai31", dut.rf[2], 32'hFFFF_FFFF);
    check("alu_sub_0m1", dut.rf[3], 32'hFFFF_FFFF);
    check("alu_x0_zero", dut.rf[5], 32'h0);
    check("alu_slt", dut.rf[8], 32'h1);
    check("alu_sltu", dut.rf[9], 32'h0);
    check("jalr_link", dut.rf[7], 32'h1000_0028);
    check("jalr_even_pc", dut.pc, 32'h1000_0034);

    // reset pulse during the EXEC cycle of the second store
    prog = {csrwi(5'd9), op_u(20'h10001, 5'd2, LUI), op_i(12'h11, 5'd0, 3'b000, 5'd1, OPI),
            op_s(12'h100, 5'd1, 5'd2, 3'b010), op_i(12'h55, 5'd0, 3'b000, 5'd1, OPI),
            op_s(12'h100, 5'd1, 5'd2, 3'b010), csrwi(5'd1)};
    run_prog(5);
    rst = 1'b0;
    repeat (22) tick();
    check("mid_state_exec", 32'(dut.state), 32'd2);
    check("mid_csr_pre", csr, 32'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_pc_restart", dut.pc, RESET_PC);
    check("mid_csr_zero", csr, 32'h0);
    check("mid_store_dropped", dut.dmem.mem[12'h440], 32'h0000_0011);
    wait_csr("mid_rerun_pass", 32'h1, 300);
    check("mid_store_rerun", dut.dmem.mem[12'h440], 32'h0000_0055);

    check("tx_idle", 32'(tx_bad), 32'h0);
    check("no_store_in_rst", 32'(rst_we), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
